// File: rtl/receivers_top_level.sv
// Two-channel Lighthouse-V2 BMC receiver front end.
// Decoded 17-bit words are reported as 3-byte 8N1 UART frames.

module bmc_decoder #(
  parameter int unsigned BIT_CYCLES   = 16,
  parameter int unsigned WORD_BITS    = 17,
  parameter int unsigned IDLE_TIMEOUT = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_env_off,
  input  logic                 i_edge,
  output logic                 o_valid_c,
  output logic [WORD_BITS-1:0] o_word_c
);
  localparam int unsigned CW       = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned NW       = $clog2(WORD_BITS + 1);
  localparam int unsigned HALF_MIN = BIT_CYCLES / 4;
  localparam int unsigned FULL_MIN = (BIT_CYCLES * 3) / 4;
  localparam int unsigned FULL_MAX = BIT_CYCLES + BIT_CYCLES / 4;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_DONE, S_ERR} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [WORD_BITS-1:0] r_shift, w_shift_n;
  logic [NW-1:0]        r_nbits, w_nbits_n;
  logic                 r_half, w_half_n;
  logic                 w_bit_en, w_bit;
  logic                 w_timeout, w_is_half, w_is_full;

  // r_cnt holds the length of the interval ending on the current cycle
  assign w_timeout = (r_cnt == CW'(IDLE_TIMEOUT));
  assign w_is_half = (r_cnt >= CW'(HALF_MIN)) && (r_cnt < CW'(FULL_MIN));
  assign w_is_full = (r_cnt >= CW'(FULL_MIN)) && (r_cnt <= CW'(FULL_MAX));
  assign o_word_c  = w_shift_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_nbits <= '0;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_shift <= w_shift_n;
      r_nbits <= w_nbits_n;
      r_half  <= w_half_n;
      if (i_edge)          r_cnt <= CW'(1);
      else if (!w_timeout) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_shift_n = r_shift;
    w_nbits_n = r_nbits;
    w_half_n  = r_half;
    o_valid_c = 1'b0;
    w_bit_en  = 1'b0;
    w_bit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_shift_n = '0;
        w_nbits_n = '0;
        w_half_n  = 1'b0;
        if (i_edge) w_next = S_PRE;
      end
      S_PRE: begin
        if (i_edge)         w_next = S_DATA;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DATA: begin
        if (i_edge) begin
          if (w_is_half && r_half) begin
            w_bit_en = 1'b1;
            w_bit    = 1'b1;
          end else if (w_is_half) begin
            w_half_n = 1'b1;
          end else if (w_is_full && !r_half) begin
            w_bit_en = 1'b1;
          end else begin
            w_next = S_ERR;
          end
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        if (!i_edge && w_timeout) w_next = S_IDLE;
      end
    endcase
    if (w_bit_en) begin
      w_shift_n = {r_shift[WORD_BITS-2:0], w_bit};
      w_nbits_n = r_nbits + NW'(1);
      w_half_n  = 1'b0;
      if (r_nbits == NW'(WORD_BITS - 1)) begin
        o_valid_c = 1'b1;
        w_next    = S_DONE;
      end
    end
    // envelope inactive overrides everything and drops partial words
    if (i_env_off) begin
      w_next    = S_IDLE;
      w_shift_n = '0;
      w_nbits_n = '0;
      w_half_n  = 1'b0;
      o_valid_c = 1'b0;
    end
  end
endmodule

module receivers_top_level #(
  parameter int unsigned BIT_CYCLES   = 16,
  parameter int unsigned WORD_BITS    = 17,
  parameter int unsigned IDLE_TIMEOUT = 24,
  parameter int unsigned BAUD_DIV     = 208
) (
  input  logic clk_96MHz,
  input  logic rst_n,
  input  logic e_in_0,
  input  logic d_in_0,
  input  logic d_in_1,
  output logic tx
);
  localparam int unsigned BW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

  logic [1:0]           r_env_s;
  logic [2:0]           r_d0_s, r_d1_s;
  logic [1:0]           w_valid;
  logic [WORD_BITS-1:0] w_word0, w_word1, w_word;
  logic [1:0]           r_pv;
  logic [WORD_BITS-1:0] r_pw0, r_pw1;
  ustate_t              r_ustate, w_unext;
  logic [BW-1:0]        r_baud;
  logic [2:0]           r_bit_idx;
  logic [1:0]           r_byte_idx;
  logic [7:0]           r_txbyte;
  logic [15:0]          r_rest;
  logic                 r_tx;
  logic                 w_baud_done, w_frame_end, w_take, w_sel;

  // 2-FF synchronizers; the third data stage is the previous sample
  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_env_s <= 2'b11;
      r_d0_s  <= '0;
      r_d1_s  <= '0;
    end else begin
      r_env_s <= {r_env_s[0], e_in_0};
      r_d0_s  <= {r_d0_s[1:0], d_in_0};
      r_d1_s  <= {r_d1_s[1:0], d_in_1};
    end
  end

  bmc_decoder #(.BIT_CYCLES(BIT_CYCLES), .WORD_BITS(WORD_BITS), .IDLE_TIMEOUT(IDLE_TIMEOUT)) u_dec0 (
    .clk(clk_96MHz), .rst_n(rst_n), .i_env_off(r_env_s[1]), .i_edge(r_d0_s[2] ^ r_d0_s[1]),
    .o_valid_c(w_valid[0]), .o_word_c(w_word0)
  );

  bmc_decoder #(.BIT_CYCLES(BIT_CYCLES), .WORD_BITS(WORD_BITS), .IDLE_TIMEOUT(IDLE_TIMEOUT)) u_dec1 (
    .clk(clk_96MHz), .rst_n(rst_n), .i_env_off(r_env_s[1]), .i_edge(r_d1_s[2] ^ r_d1_s[1]),
    .o_valid_c(w_valid[1]), .o_word_c(w_word1)
  );

  assign w_baud_done = (r_ustate != U_IDLE) && (r_baud == BW'(BAUD_DIV - 1));
  assign w_frame_end = (r_ustate == U_STOP) && w_baud_done && (r_byte_idx == 2'd2);
  assign w_take      = ((r_ustate == U_IDLE) || w_frame_end) && (|r_pv);
  assign w_sel       = ~r_pv[0];
  assign w_word      = w_sel ? r_pw1 : r_pw0;
  assign tx          = r_tx;

  // a fresh word overwrites an unsent one; the arbiter clears what it takes
  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pv  <= '0;
      r_pw0 <= '0;
      r_pw1 <= '0;
    end else begin
      if (w_valid[0]) begin
        r_pv[0] <= 1'b1;
        r_pw0   <= w_word0;
      end else if (w_take && !w_sel) begin
        r_pv[0] <= 1'b0;
      end
      if (w_valid[1]) begin
        r_pv[1] <= 1'b1;
        r_pw1   <= w_word1;
      end else if (w_take && w_sel) begin
        r_pv[1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) r_ustate <= U_IDLE;
    else        r_ustate <= w_unext;
  end

  always_comb begin
    w_unext = r_ustate;
    case (r_ustate)
      U_IDLE:  if (w_take) w_unext = U_START;
      U_START: if (w_baud_done) w_unext = U_DATA;
      U_DATA:  if (w_baud_done && (r_bit_idx == 3'd7)) w_unext = U_STOP;
      U_STOP: begin
        if (w_baud_done) begin
          if (r_byte_idx != 2'd2) w_unext = U_START;
          else if (w_take)        w_unext = U_START;
          else                    w_unext = U_IDLE;
        end
      end
      default: w_unext = U_IDLE;
    endcase
  end

  // UART datapath: tx is updated on the cycle each bit period ends
  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_txbyte   <= '0;
      r_rest     <= '0;
    end else begin
      r_baud <= (r_ustate == U_IDLE || w_baud_done) ? '0 : r_baud + BW'(1);
      if (w_take) begin
        r_tx       <= 1'b0;
        r_txbyte   <= {w_sel, 6'b0, w_word[16]};
        r_rest     <= w_word[15:0];
        r_byte_idx <= 2'd0;
      end else if (w_baud_done) begin
        case (r_ustate)
          U_START: begin
            r_tx      <= r_txbyte[0];
            r_bit_idx <= 3'd0;
          end
          U_DATA: begin
            if (r_bit_idx == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx      <= r_txbyte[1];
              r_txbyte  <= {1'b0, r_txbyte[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
          U_STOP: begin
            if (r_byte_idx != 2'd2) begin
              r_tx       <= 1'b0;
              r_txbyte   <= r_rest[15:8];
              r_rest     <= {r_rest[7:0], 8'h00};
              r_byte_idx <= r_byte_idx + 2'd1;
            end else begin
              r_tx <= 1'b1;
            end
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_receivers_top_level.sv
// Directed bench for receivers_top_level: BMC bursts in, UART bytes decoded and compared.

module tb_receivers_top_level;
  localparam int BAUD = 208;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e_in_0;
  logic       d_in_0;
  logic       d_in_1;
  logic [1:0] d_dly = 2'b00;
  logic       tx;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  bit         mon_en = 1'b1;
  int         tx_falls = 0;
  int         frame_errs = 0;
  logic [7:0] mon_b;
  bit         mon_ok;

  typedef struct {
    logic [16:0] word;
    int          nbits;
    bit          jit;
    int          drop_at;
    int          exp_n;
    logic [47:0] exp_bytes;
  } vec_t;

  vec_t vecs[6];

  receivers_top_level dut (
    .clk_96MHz(clk), .rst_n(rst_n), .e_in_0(e_in_0),
    .d_in_0(d_in_0), .d_in_1(d_in_1), .tx(tx)
  );

  always #5 clk = ~clk;

  // sensor 1 sees the same burst two cycles later
  always @(posedge clk) d_dly <= {d_dly[0], d_in_0};
  assign d_in_1 = d_dly[1];

  always @(negedge tx) if (mon_en) tx_falls++;

  // UART receiver: samples mid-bit on the falling clock edge
  initial begin
    forever begin
      @(negedge tx);
      if (mon_en) begin
        repeat (BAUD / 2) @(negedge clk);
        mon_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (BAUD) @(negedge clk);
        if (mon_en) begin
          if (!mon_ok || tx !== 1'b1) frame_errs++;
          rx_q.push_back(mon_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tog();
    #1 d_in_0 = ~d_in_0;
  endtask

  task automatic wait_iv(input int n, input bit jit);
    int d;
    d = n;
    if (jit) d = n + int'($urandom_range(6)) - 3;
    repeat (d) @(posedge clk);
  endtask

  task automatic send_burst(input logic [16:0] w, input int nbits, input bit jit, input int drop_at);
    @(posedge clk);
    tog();
    wait_iv(8, jit);
    tog();
    for (int i = 0; i < nbits; i++) begin
      if (drop_at == i) e_in_0 = 1'b1;
      if (w[16-i]) begin
        wait_iv(8, jit);
        tog();
        wait_iv(8, jit);
        tog();
      end else begin
        wait_iv(16, jit);
        tog();
      end
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int base, f0, fe0, n;
    logic [47:0] eb;
    e_in_0 = 1'b0;
    repeat (40) @(posedge clk);
    base = rx_q.size();
    f0   = tx_falls;
    fe0  = frame_errs;
    send_burst(v.word, v.nbits, v.jit, v.drop_at);
    if (v.exp_n > 0) begin
      n = 0;
      while (tx !== 1'b0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_start_latency"}, 32'(tx), 32'd0);
    end
    repeat (60) @(posedge clk);
    #1 e_in_0 = 1'b1;
    if (v.exp_n > 0) begin
      n = 0;
      while (rx_q.size() < base + v.exp_n && n < v.exp_n * 10 * BAUD + 2000) begin
        @(negedge clk);
        n++;
      end
      repeat (BAUD) @(negedge clk);
    end else begin
      repeat (300) @(negedge clk);
      check({tag, "_no_tx"}, 32'(tx_falls - f0), 32'd0);
    end
    check({tag, "_nbytes"}, 32'(rx_q.size() - base), 32'(v.exp_n));
    eb = v.exp_bytes;
    for (int k = 0; k < v.exp_n; k++) begin
      if (base + k < rx_q.size())
        check($sformatf("%s_byte%0d", tag, k), 32'(rx_q[base+k]), 32'(eb[47-8*k -: 8]));
      else
        check($sformatf("%s_byte%0d_missing", tag, k), 32'd1, 32'd0);
    end
    check({tag, "_framing"}, 32'(frame_errs - fe0), 32'd0);
  endtask

  initial begin
    int f0, n;
    vec_t rv;
    vecs[0] = '{word: 17'h17274, nbits: 17, jit: 1'b0, drop_at: -1, exp_n: 6, exp_bytes: 48'h01_72_74_81_72_74};
    vecs[1] = '{word: 17'h0A5C3, nbits: 17, jit: 1'b1, drop_at: -1, exp_n: 6, exp_bytes: 48'h00_A5_C3_80_A5_C3};
    vecs[2] = '{word: 17'h1FFFF, nbits: 10, jit: 1'b0, drop_at: -1, exp_n: 0, exp_bytes: 48'h0};
    vecs[3] = '{word: 17'h1FFFF, nbits: 17, jit: 1'b0, drop_at: -1, exp_n: 6, exp_bytes: 48'h01_FF_FF_81_FF_FF};
    vecs[4] = '{word: 17'h00000, nbits: 17, jit: 1'b1, drop_at: -1, exp_n: 6, exp_bytes: 48'h00_00_00_80_00_00};
    vecs[5] = '{word: 17'h12345, nbits: 17, jit: 1'b0, drop_at: 8,  exp_n: 0, exp_bytes: 48'h0};

    // reset held with random inputs
    rst_n  = 1'b0;
    e_in_0 = 1'b1;
    d_in_0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      e_in_0 = 1'($urandom_range(1));
      d_in_0 = 1'($urandom_range(1));
      @(negedge clk);
      check("reset_tx_high", 32'(tx), 32'd1);
    end
    @(posedge clk);
    #1 e_in_0 = 1'b1;
    rst_n = 1'b1;
    f0 = tx_falls;
    for (int i = 0; i < 25; i++) begin
      repeat (8) @(posedge clk);
      tog();
    end
    repeat (100) @(negedge clk);
    check("env_off_no_tx", 32'(tx_falls - f0), 32'd0);
    check("env_off_tx_idle", 32'(tx), 32'd1);

    for (int v = 0; v < 6; v++) run_vector(vecs[v], $sformatf("vec%0d", v));

    // half bit followed by a full bit interval -> error, no frame
    e_in_0 = 1'b0;
    repeat (40) @(posedge clk);
    f0 = tx_falls;
    @(posedge clk);
    tog();
    wait_iv(8, 1'b0); tog();
    wait_iv(8, 1'b0); tog();
    wait_iv(16, 1'b0); tog();
    for (int i = 0; i < 20; i++) begin
      wait_iv(16, 1'b0);
      tog();
    end
    repeat (300) @(negedge clk);
    check("error_no_tx", 32'(tx_falls - f0), 32'd0);
    rv = '{word: 17'h10001, nbits: 17, jit: 1'b0, drop_at: -1, exp_n: 6, exp_bytes: 48'h01_00_01_81_00_01};
    run_vector(rv, "recover");

    // asynchronous reset in the middle of a frame
    e_in_0 = 1'b0;
    repeat (40) @(posedge clk);
    send_burst(17'h17274, 17, 1'b0, -1);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (1000) @(posedge clk);
    #2;
    check("midframe_tx_low", 32'(tx), 32'd0);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("midframe_reset_tx", 32'(tx), 32'd1);
    e_in_0 = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12 * BAUD) @(posedge clk);
    mon_en = 1'b1;
    f0 = tx_falls;
    repeat (500) @(negedge clk);
    check("after_reset_no_tx", 32'(tx_falls - f0), 32'd0);
    check("after_reset_tx_idle", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
